ccd_window_gen: RTL and testbench

Parametrised K×K neighbourhood window generator for the CCD edge pipeline. It sits between the line-buffer RAMs and the edge/convolution kernels. Each cycle it picks which line-buffer tap feeds each window row, using an internal row-rotation pointer rather than external select lines. It delays the pixels through per-row strided shift registers, qualifies output with a frame/row fill state machine and can optionally mask columns that straddle a row boundary.

---
 rtl/ccd_window_gen_pkg.sv | 19 +
 rtl/ccd_window_gen_if.sv | 24 ++
 rtl/ccd_window_gen_tap_line.sv | 46 ++++
 rtl/ccd_window_gen.sv | 105 ++++++++++
 tb/tb_ccd_window_gen.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ccd_window_gen_pkg.sv
// rtl/ccd_window_gen_pkg.sv - shared types and helpers for the CCD window generator
package ccd_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } win_state_t;

  localparam int DEF_K      = 3;
  localparam int DEF_STRIDE = 2;
  localparam int SR_DEPTH   = (DEF_K - 1) * DEF_STRIDE + 1;

  // Register stage (1-based) that feeds window column c
  function automatic int tap_depth(input int c, input int k, input int stride);
    return (k - 1 - c) * stride + 1;
  endfunction

endpackage

// File: rtl/ccd_window_gen_if.sv
// rtl/ccd_window_gen_if.sv - pixel/tap inputs and window outputs of the window generator
interface ccd_window_gen_if #(
  parameter int DW   = 10,
  parameter int K    = 3,
  parameter int NBUF = 3
);
  logic                  frame_start;
  logic                  pix_valid;
  logic                  row_end;
  logic [NBUF*DW-1:0]    ram_data;
  logic [K*K*DW-1:0]     win;
  logic                  win_valid;
  logic [K-1:0]          edge_mask;

  modport master (
    output frame_start, pix_valid, row_end, ram_data,
    input  win, win_valid, edge_mask
  );

  modport slave (
    input  frame_start, pix_valid, row_end, ram_data,
    output win, win_valid, edge_mask
  );
endinterface

// File: rtl/ccd_window_gen_tap_line.sv
// rtl/ccd_window_gen_tap_line.sv - one window row: tap mux plus pixel-gated strided shift register
module ccd_tap_line
  import ccd_window_pkg::*;
#(
  parameter int DW     = 10,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int NBUF   = 3,
  parameter int DEPTH  = SR_DEPTH,
  localparam int SW    = $clog2(NBUF)
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic [NBUF*DW-1:0] ram_data,
  input  logic [SW-1:0]      sel,
  input  logic               zero_force,
  input  logic               adv,
  output logic [K*DW-1:0]    taps
);

  logic [DW-1:0] mux_out;
  logic [DW-1:0] sr [1:DEPTH];

  always_comb begin
    mux_out = '0;
    if (!zero_force) begin
      for (int n = 0; n < NBUF; n++) begin
        if (sel == SW'(n)) mux_out = ram_data[n*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int i = 1; i <= DEPTH; i++) sr[i] <= '0;
    end else if (adv) begin
      sr[1] <= mux_out;
      for (int i = 2; i <= DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  for (genvar c = 0; c < K; c++) begin : g_col
    assign taps[c*DW +: DW] = sr[tap_depth(c, K, STRIDE)];
  end

endmodule

// File: rtl/ccd_window_gen.sv
// rtl/ccd_window_gen.sv - KxK window generator with row rotation and fill FSM; WINDOW_EDGE_MASK_EN enables column boundary masking
module ccd_window_gen
  import ccd_window_pkg::*;
#(
  parameter int DW     = 10,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int NBUF   = 3
) (
  input  logic            clk,
  input  logic            aclr,
  ccd_window_gen_if.slave bus
);

  localparam int SRD = tap_depth(0, K, STRIDE);
  localparam int RW  = $clog2(NBUF);
  localparam int RSW = $clog2(K);
  localparam int CW  = $clog2(SRD + 1);

  if (NBUF < K || K < 3 || K > 7 || (K % 2) == 0) begin : g_bad_cfg
    $error("ccd_window_gen: K must be odd in 3..7 and NBUF >= K");
  end

  win_state_t     state;
  logic [RW-1:0]  rot;
  logic [RSW-1:0] rows_seen;
  logic           win_valid_q;
  logic [K-1:0]   mask;
  logic [K*DW-1:0] row_taps [K];

  // frame_start has priority over row_end; counters update after a coincident pixel
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state       <= ST_IDLE;
      rot         <= '0;
      rows_seen   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      win_valid_q <= bus.pix_valid && (state == ST_RUN);
      if (bus.frame_start) begin
        state     <= ST_FILL;
        rot       <= '0;
        rows_seen <= '0;
      end else if (bus.row_end) begin
        rot <= (rot == RW'(NBUF - 1)) ? '0 : rot + 1'b1;
        if (rows_seen != RSW'(K - 1)) rows_seen <= rows_seen + 1'b1;
        if (state == ST_FILL && rows_seen == RSW'(K - 2)) state <= ST_RUN;
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    logic [RW:0]   sum;
    logic [RW-1:0] sel;

    // rot < NBUF and r < NBUF, so one conditional subtract gives the modulo
    assign sum = {1'b0, rot} + (RW+1)'(r);
    assign sel = (sum >= (RW+1)'(NBUF)) ? RW'(sum - (RW+1)'(NBUF)) : sum[RW-1:0];

    ccd_tap_line #(
      .DW    (DW),
      .K     (K),
      .STRIDE(STRIDE),
      .NBUF  (NBUF),
      .DEPTH (SRD)
    ) u_line (
      .clk       (clk),
      .aclr      (aclr),
      .ram_data  (bus.ram_data),
      .sel       (sel),
      .zero_force(state == ST_IDLE),
      .adv       (bus.pix_valid),
      .taps      (row_taps[r])
    );

    for (genvar c = 0; c < K; c++) begin : g_col
      assign bus.win[(r*K + c)*DW +: DW] = mask[c] ? '0 : row_taps[r][c*DW +: DW];
    end
  end

`ifdef WINDOW_EDGE_MASK_EN
  logic [CW-1:0] col_cnt;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      col_cnt <= '0;
    end else if (bus.frame_start || bus.row_end) begin
      col_cnt <= '0;
    end else if (bus.pix_valid && col_cnt != CW'(SRD)) begin
      col_cnt <= col_cnt + 1'b1;
    end
  end

  // A column is masked until its stage holds a pixel from the current row
  for (genvar c = 0; c < K; c++) begin : g_mask
    assign mask[c] = (state != ST_IDLE) && (col_cnt <= CW'(tap_depth(c, K, STRIDE) - 1));
  end
`else
  assign mask = '0;
`endif

  assign bus.edge_mask = mask;
  assign bus.win_valid = win_valid_q;

endmodule

// File: tb/tb_ccd_window_gen.sv
// tb/tb_ccd_window_gen.sv - self-checking bench for ccd_window_gen against a queue-based reference model
module tb_ccd_window_gen;
  import ccd_window_pkg::*;

  localparam int DW = 10, K = 3, STRIDE = 2, NBUF = 3;
  localparam int SRD = (K - 1) * STRIDE + 1;

  logic clk = 1'b0;
  logic aclr = 1'b0;
  int checks = 0;
  int failures = 0;

  ccd_window_gen_if #(.DW(DW), .K(K), .NBUF(NBUF)) bus ();

  ccd_window_gen #(.DW(DW), .K(K), .STRIDE(STRIDE), .NBUF(NBUF)) dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // hist[0] is the newest accepted pixel; each entry holds the value every row saw
  logic [K*DW-1:0] hist[$];
  int m_state, m_rot, m_rows, m_col;  // m_state: 0 idle, 1 fill, 2 run
  logic [K*K*DW-1:0] exp_win;
  logic              exp_valid;
  logic [K-1:0]      exp_mask;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_state = 0; m_rot = 0; m_rows = 0; m_col = 0;
    exp_win = '0; exp_valid = 1'b0; exp_mask = '0;
  endtask

  task automatic model_step(input logic fs, input logic pv, input logic re,
                            input logic [NBUF*DW-1:0] d);
    logic [K*DW-1:0] e;
    logic [DW-1:0]   v;
    logic            masked;
    int              back;
    e = '0;
    exp_valid = pv && (m_state == 2);
    if (pv) begin
      for (int r = 0; r < K; r++)
        e[r*DW +: DW] = (m_state == 0) ? '0 : d[((m_rot + r) % NBUF)*DW +: DW];
      hist.push_front(e);
      if (hist.size() > SRD) void'(hist.pop_back());
    end
    if (fs) begin
      m_state = 1; m_rot = 0; m_rows = 0; m_col = 0;
    end else if (re) begin
      if (m_state == 1 && m_rows + 1 == K - 1) m_state = 2;
      m_rot = (m_rot + 1) % NBUF;
      if (m_rows < K - 1) m_rows++;
      m_col = 0;
    end else if (pv && m_col < SRD) begin
      m_col++;
    end
    for (int c = 0; c < K; c++) begin
      back = (K - 1 - c) * STRIDE;
`ifdef WINDOW_EDGE_MASK_EN
      masked = (m_state != 0) && (m_col <= back);
`else
      masked = 1'b0;
`endif
      exp_mask[c] = masked;
      for (int r = 0; r < K; r++) begin
        v = (hist.size() > back) ? hist[back][r*DW +: DW] : '0;
        exp_win[(r*K + c)*DW +: DW] = masked ? '0 : v;
      end
    end
  endtask

  task automatic drive(input logic fs, input logic pv, input logic re,
                       input logic [NBUF*DW-1:0] d);
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.row_end     = re;
    bus.ram_data    = d;
    model_step(fs, pv, re, d);
    @(posedge clk);
    #1;
    chk("win", 128'(bus.win), 128'(exp_win));
    chk("win_valid", 128'(bus.win_valid), 128'(exp_valid));
    chk("edge_mask", 128'(bus.edge_mask), 128'(exp_mask));
  endtask

  function automatic logic [NBUF*DW-1:0] rnd_taps();
    logic [NBUF*DW-1:0] t;
    for (int n = 0; n < NBUF; n++) t[n*DW +: DW] = DW'($urandom);
    return t;
  endfunction

  initial begin
    logic [DW-1:0]       pv_val;
    logic [NBUF*DW-1:0]  d;
    logic [K*K*DW-1:0]   prev;
    logic                pv;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.row_end     = 1'b0;
    bus.ram_data    = '0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_win", 128'(bus.win), 128'(0));
    chk("rst_valid", 128'(bus.win_valid), 128'(0));
    chk("rst_mask", 128'(bus.edge_mask), 128'(0));
    chk("rst_state", 128'(dut.state), 128'(ST_IDLE));
    chk("rst_rot", 128'(dut.rot), 128'(0));
    aclr = 1'b1;

    // idle: all-ones taps without frame_start must not leak
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, {NBUF{10'h3FF}});
      chk("idle_win", 128'(bus.win), 128'(0));
    end

    // fill: two rows, the second row_end enters RUN
    drive(1'b1, 1'b0, 1'b0, rnd_taps());
    chk("fs_state", 128'(dut.state), 128'(ST_FILL));
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, rnd_taps());
    drive(1'b0, 1'b1, 1'b1, rnd_taps());
    chk("fill_state", 128'(dut.state), 128'(ST_FILL));
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, rnd_taps());
    drive(1'b0, 1'b0, 1'b1, rnd_taps());
    chk("run_state", 128'(dut.state), 128'(ST_RUN));
    chk("run_rot", 128'(dut.rot), 128'(2));

    // column strides: pixels 1..7 on every tap
    for (int i = 1; i <= 7; i++) begin
      pv_val = DW'(i);
      drive(1'b0, 1'b1, 1'b0, {NBUF{pv_val}});
    end
    chk("stride_c2", 128'(bus.win[2*DW +: DW]), 128'(7));
    chk("stride_c1", 128'(bus.win[1*DW +: DW]), 128'(5));
    chk("stride_c0", 128'(bus.win[0 +: DW]), 128'(3));
    chk("stride_valid", 128'(bus.win_valid), 128'(1));

    // valid gating: window holds while pix_valid is low
    for (int i = 0; i < 8; i++) begin
      pv = (i % 2 == 0);
      prev = bus.win;
      drive(1'b0, pv, 1'b0, rnd_taps());
      if (!pv) chk("gate_hold", 128'(bus.win), 128'(prev));
    end

    // rotation wrap: row 0 moves from tap 2 to tap 0
    d = {10'h103, 10'h102, 10'h101};
    drive(1'b0, 1'b1, 1'b0, d);
    chk("rot_before", 128'(bus.win[2*DW +: DW]), 128'(10'h103));
    drive(1'b0, 1'b0, 1'b1, d);
    chk("rot_wrap", 128'(dut.rot), 128'(0));
    chk("rows_sat", 128'(dut.rows_seen), 128'(K - 1));
    drive(1'b0, 1'b1, 1'b0, d);
    chk("rot_after_r0", 128'(bus.win[2*DW +: DW]), 128'(10'h101));
    chk("rot_after_r1", 128'(bus.win[(K + 2)*DW +: DW]), 128'(10'h102));
`ifdef WINDOW_EDGE_MASK_EN
    chk("mask_first", 128'(bus.edge_mask), 128'(3'b011));
`else
    chk("mask_first", 128'(bus.edge_mask), 128'(0));
`endif
    for (int p = 2; p <= 6; p++) begin
      drive(1'b0, 1'b1, 1'b0, rnd_taps());
`ifdef WINDOW_EDGE_MASK_EN
      if (p == 3) chk("mask_p3", 128'(bus.edge_mask), 128'(3'b001));
`else
      if (p == 3) chk("mask_p3", 128'(bus.edge_mask), 128'(0));
`endif
      if (p == 5) chk("mask_p5", 128'(bus.edge_mask), 128'(0));
    end

    // frame_start with row_end during RUN
    drive(1'b1, 1'b1, 1'b1, rnd_taps());
    chk("sim_state", 128'(dut.state), 128'(ST_FILL));
    chk("sim_rot", 128'(dut.rot), 128'(0));
    chk("sim_rows", 128'(dut.rows_seen), 128'(0));

    // back into RUN, then asynchronous reset mid-stream
    for (int row = 0; row < 2; row++) begin
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, rnd_taps());
      drive(1'b0, 1'b0, 1'b1, rnd_taps());
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, rnd_taps());
    bus.pix_valid = 1'b1;
    #3;
    aclr = 1'b0;
    #1;
    chk("arst_win", 128'(bus.win), 128'(0));
    chk("arst_valid", 128'(bus.win_valid), 128'(0));
    chk("arst_state", 128'(dut.state), 128'(ST_IDLE));
    model_reset();
    @(posedge clk);
    #1;
    aclr = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++)
      drive(($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 9) == 0, rnd_taps());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
